fifo_read_adapter: RTL and testbench
====================================

// Module: fifo_read_adapter
// PURPOSE
// - Read-side consumer of the async FIFO, running in the read clock domain.
// - Drives rinc from rempty and captures rdata.
// - Re-presents the words as a valid/ready stream through a 2-entry skid buffer.
// - Marks every BURST_LEN-th word delivered with m_last.
// - Sits between the FIFO read port and downstream stream logic.
// PARAMETERS
// - DSIZE      fifo_pkg::DSIZE (8)  data width; must match the FIFO's rdata width
// - BURST_LEN  4                    words per frame; legal range 1..256
// - STAT_W     16                   width of the optional statistics counters
// PORTS
// - rclk       in   1          read clock; the only clock of this block
// - rrst_n     in   1          asynchronous active-low reset
// - rempty     in   1          FIFO empty flag, already synchronous to rclk
// - rdata      in   DSIZE      FIFO head word; valid while rempty==0
// - rinc       out  1          pop strobe to the FIFO
// - m_valid    out  1          stream data valid
// - m_ready    in   1          stream sink ready
// - m_data     out  DSIZE      stream data
// - m_last     out  1          last word of the current frame
// - stat_words out  STAT_W     words delivered (FIFO_RD_STATS_EN only)
// - stat_stall out  STAT_W     backpressure cycles (FIFO_RD_STATS_EN only)
// BEHAVIOUR
// - Reset values: rinc=0, m_valid=0, m_data=0, m_last=0, occupancy=0,
//   beat counter=0, stats=0, run_q=0.
// - run_q is a registered enable that goes to 1 on the first rclk edge after
//   rrst_n deasserts.
// - rinc = run_q & !rempty & (occ < 2).
//   - occ is registered; m_ready is not in the rinc path.
// - Pop timing: on the rclk edge where rinc==1, rdata is written to the buffer tail.
//   - The word is visible on m_data one cycle after the rinc cycle.
//   - Pop-to-output latency is 1 cycle.
// - Output transfer: happens when m_valid & m_ready; the head entry is retired.
//   m_valid = (occ != 0).
// - Occupancy FSM, with push=rinc and pop=m_valid&m_ready:
//   - EMPTY(0): push -> ONE; otherwise stay EMPTY.
//   - ONE(1): push&!pop -> FULL; pop&!push -> EMPTY; push&pop or neither -> stay ONE.
//   - FULL(2): rinc is 0 here; pop -> ONE; otherwise stay FULL.
// - Full throughput is 1 word/cycle while m_ready==1 and the FIFO is non-empty.
// - FULL is reached only under backpressure.
// - Backpressure: m_data and m_last hold stable while m_valid & !m_ready.
// - Beat counter (0..BURST_LEN-1):
//   - Increments on each transfer and wraps to 0 after BURST_LEN-1.
//   - m_last = m_valid & (beat == BURST_LEN-1).
//   - With BURST_LEN==1, m_last == m_valid.
// - rempty rising in the same cycle as a pop: rinc is evaluated on the current rempty only.
//   - The FIFO guarantees rempty==0 implies rdata is valid.
//   - No pop is issued on a cycle where rempty==1.
// - Reset mid-operation: asynchronously clears all state, including any buffered words.
//   - rinc drops immediately because run_q is cleared.
//   - Words already buffered are lost; the FIFO itself is reset independently.
// - A value of X on rdata while rempty==1 must never propagate to m_data.
// CONFIGURATION
// - FIFO_RD_STATS_EN defined:
//   - stat_words increments on every transfer; stat_stall increments on every
//     m_valid & !m_ready cycle.
//   - Both counters saturate at all-ones and clear on reset.
// - FIFO_RD_STATS_EN undefined:
//   - stat_words and stat_stall are tied to 0; no counter flops are built.
// STRUCTURE
// - fifo_pkg holds:
//   - DSIZE;
//   - typedef logic [DSIZE-1:0] data_t;
//   - enum {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_e.
// - Sub-module fifo_skid_buf: 2-entry buffer with push/pop and the occ_e FSM;
//   carries only data.
// - The top level holds: run_q, rinc generation, the beat counter, m_last, and stats.
// TESTING
// - Reset release, FIFO preloaded with 0x11,0x22,0x33 and m_ready=1:
//   - rinc is high on cycles 2-4.
//   - m_data shows 0x11,0x22,0x33 on consecutive cycles, with no gaps.
// - 8 words 0x00..0x07, BURST_LEN=4, m_ready=1:
//   - m_last is high with 0x03 and with 0x07 only.
// - m_ready=0 for 5 cycles with the FIFO non-empty:
//   - Exactly 2 pops occur, then rinc=0 and m_data is held.
//   - stat_stall=5 when FIFO_RD_STATS_EN is defined.
// - rempty held 1 with rdata=X: rinc=0, m_valid=0, m_data never X.
// - rrst_n pulsed low while occ=2 and beat=2:
//   - m_valid=0 and rinc=0 immediately.
//   - After release, the next word restarts at beat 0.
// - FIFO_RD_STATS_EN with STAT_W=4, 20 words delivered:
//   - stat_words saturates at 15.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read side: data width, data word type and
// the occupancy encoding used by the skid buffer.
package fifo_pkg;

  localparam int DSIZE = 8;

  typedef logic [DSIZE-1:0] data_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer carrying data only. Occupancy is tracked by an
// occ_e FSM; push and pop may happen in the same cycle.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DSIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output occ_e         occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // NOTE: both entries are reset so head reads 0 after reset and can never
  // expose an uninitialised value; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= OCC_EMPTY;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      // NOTE: the default arm keeps the FSM fully specified for every encoding.
      unique case (occ)
        OCC_EMPTY: if (push) occ <= OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      occ <= OCC_FULL;
          else if (pop && !push) occ <= OCC_EMPTY;
        end
        OCC_FULL:  if (pop) occ <= OCC_ONE;
        default:   occ <= OCC_EMPTY;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_read_adapter.sv
// FIFO read-port consumer: pops via rinc into a 2-entry skid buffer and
// re-presents words as a valid/ready stream with m_last every BURST_LEN
// beats. Optional counters are built when FIFO_RD_STATS_EN is defined.
module fifo_read_adapter
  import fifo_pkg::*;
#(
  parameter int DSIZE     = fifo_pkg::DSIZE,
  parameter int BURST_LEN = 4,
  parameter int STAT_W    = 16
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rempty,
  input  logic [DSIZE-1:0]  rdata,
  output logic              rinc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DSIZE-1:0]  m_data,
  output logic              m_last,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_stall
);

  localparam int              BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  occ_e              occ;
  logic              run_q;
  logic [BEAT_W-1:0] beat;
  logic              xfer;

  fifo_skid_buf #(.W(DSIZE)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc),
    .pop       (xfer),
    .push_data (rdata),
    .head      (m_data),
    .occ       (occ)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // Popping depends only on registered occupancy, so m_ready never reaches rinc.
  assign rinc    = run_q & ~rempty & (occ != OCC_FULL);
  assign m_valid = (occ != OCC_EMPTY);
  assign xfer    = m_valid & m_ready;
  assign m_last  = m_valid & (beat == BEAT_MAX);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)   beat <= '0;
    else if (xfer) beat <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
  end

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] words_q;
  logic [STAT_W-1:0] stall_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (xfer && (words_q != '1))                  words_q <= words_q + 1'b1;
      if (m_valid && !m_ready && (stall_q != '1))   stall_q <= stall_q + 1'b1;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`else
  assign stat_words = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Scoreboard bench for fifo_read_adapter: a queue-based FIFO model feeds
// the DUT, expected words are queued at push time and checked by a monitor.
module tb_fifo_read_adapter;

  localparam int BL = 4;
  localparam int SW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          rempty;
  logic [7:0]    rdata;
  logic          rinc;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [7:0]    m_data;
  logic          m_last;
  logic [SW-1:0] stat_words;
  logic [SW-1:0] stat_stall;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int         beat_m = 0;
  int         pop_cnt = 0;
  int         lasts_seen = 0;
  logic       pop_now = 1'b0;

  fifo_read_adapter #(.BURST_LEN(BL), .STAT_W(SW)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .stat_words (stat_words),
    .stat_stall (stat_stall)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'hxx : fifo_q[0];
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back({(beat_m == BL - 1), w});
    beat_m = (beat_m + 1) % BL;
    refresh();
  endtask

  task automatic clear_models();
    fifo_q.delete();
    exp_q.delete();
    beat_m = 0;
    refresh();
  endtask

  task automatic reset_dut();
    @(posedge rclk); #2;
    rrst_n = 1'b0;
    clear_models();
    @(posedge rclk); #2;
    rrst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int left = 200;
    while (exp_q.size() != 0 && left > 0) begin
      @(negedge rclk);
      left--;
    end
    check(name, exp_q.size(), 0);
  endtask

  // FIFO model: sample the pop strobe mid-cycle, retire the head after the edge.
  always @(negedge rclk) pop_now = rinc;
  always @(posedge rclk) begin
    #1;
    if (pop_now && rrst_n && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    refresh();
  end

  // Monitor: every accepted word is compared with the head of the scoreboard.
  always @(negedge rclk) begin
    logic [8:0] e;
    if (rrst_n && m_valid && m_ready) begin
      if (m_last) lasts_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%0h, expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        check("m_data", m_data, e[7:0]);
        check("m_last", m_last, e[8]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] exp_rinc;
    logic [5:0] exp_valid;
    int         p0;
    int         stalls;
    int         left;

    refresh();
    #1;
    check("rst_rinc",    rinc,       0);
    check("rst_m_valid", m_valid,    0);
    check("rst_m_data",  m_data,     0);
    check("rst_m_last",  m_last,     0);
    check("rst_words",   stat_words, 0);
    check("rst_stall",   stat_stall, 0);

    // Preloaded FIFO, release from reset, back-to-back delivery.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    @(posedge rclk); #2;
    rrst_n    = 1'b1;
    exp_rinc  = 6'b001110;
    exp_valid = 6'b011100;
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      check($sformatf("start_rinc_%0d", i),  rinc,    exp_rinc[i]);
      check($sformatf("start_valid_%0d", i), m_valid, exp_valid[i]);
    end
    wait_drain("drain_start");

    // Eight words: m_last only on 0x03 and 0x07.
    reset_dut();
    lasts_seen = 0;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    wait_drain("drain_burst");
    check("last_count", lasts_seen, 2);

    // Empty FIFO with rdata = X.
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("xempty_rinc",  rinc,              0);
      check("xempty_valid", m_valid,           0);
      check("xempty_known", $isunknown(m_data), 0);
    end

    // Backpressure for five valid cycles.
    @(posedge rclk); #2;
    m_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
    stalls = 0;
    left   = 20;
    while (stalls < 5 && left > 0) begin
      @(negedge rclk);
      left--;
      if (m_valid) begin
        stalls++;
        check("stall_hold", m_data, 8'h40);
        if (stalls > 1) check("stall_rinc", rinc, 0);
      end
    end
    check("stall_cycles", stalls, 5);
    @(posedge rclk); #2;
    m_ready = 1'b1;
    check("stall_pops", pop_cnt - p0, 2);
`ifdef FIFO_RD_STATS_EN
    check("stat_stall", stat_stall, 5);
`else
    check("stat_stall", stat_stall, 0);
`endif
    wait_drain("drain_stall");

    // Reset while the buffer is full at beat 2.
    reset_dut();
    push_word(8'h50);
    push_word(8'h51);
    wait_drain("drain_pre");
    @(posedge rclk); #2;
    m_ready = 1'b0;
    push_word(8'h60);
    push_word(8'h61);
    push_word(8'h62);
    repeat (4) @(negedge rclk);
    check("full_valid", m_valid, 1);
    check("full_rinc",  rinc,    0);
    check("full_last",  m_last,  0);
    @(posedge rclk); #2;
    rrst_n = 1'b0;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_rinc",  rinc,    0);
    clear_models();
    @(posedge rclk); #2;
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'h70 + 8'(i));
    wait_drain("drain_post_rst");

    // Sixteen more words, twenty delivered since the last reset.
    for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
    wait_drain("drain_sat");
    @(negedge rclk);
`ifdef FIFO_RD_STATS_EN
    check("stat_words_sat", stat_words, 15);
`else
    check("stat_words_sat", stat_words, 0);
`endif
    check("stat_stall_zero", stat_stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
